str_to_float: RTL and testbench
===============================

Name: str_to_float

Overview:
- Parses a serial ASCII decimal string, one character per handshake (typically from the UART/keypad receive path), into a signed 64-bit fixed-point value scaled by 10^6.
- Its output uses the same number format that the display string formatter consumes, so a parsed value can be fed straight back for printing.
- Grammar: [sign] digits [ '.' digits ] TERM.

Parameters:
- INT_DIGITS, 6: maximum number of integer digits accepted.
- FRAC_DIGITS, 6: maximum number of fraction digits accepted; the result is scaled by 10^FRAC_DIGITS.
- SCALE, 1000000: integer scale factor; must equal 10^FRAC_DIGITS.
- TERM, 8'h0D: terminator character.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- char_in  in  8  ASCII character.
- char_valid  in  1  char_in is valid this cycle.
- char_ready  out  1  parser accepts a character this cycle; a character is consumed only when char_valid && char_ready.
- float  out  64  two's-complement result, value × SCALE; holds its value until the next successful parse.
- validout  out  1  one-cycle pulse: a new float is valid.
- error  out  1  one-cycle pulse: malformed string rejected.

Behaviour:
- Reset values: float=0, validout=0, error=0, char_ready=1, state=SIGN, accumulators, counters and negative flag cleared.
- States: SIGN, INT, FRAC, PAD, OUT, FLUSH.
- char_ready=1 in SIGN, INT, FRAC and FLUSH; 0 in PAD and OUT. char_valid while char_ready=0 is ignored; the sender holds the character.
- SIGN, on accept:
  - '+' or '-': latch negative ('-' sets it) -> INT.
  - digit: accumulate as the first integer digit -> INT.
  - '.': -> FRAC.
  - TERM or any other character: error path.
- INT:
  - digit: int_acc = int_acc*10 + d, computed as (acc<<3)+(acc<<1)+d; nint++.
  - '.': -> FRAC.
  - TERM: -> PAD.
  - Error if nint would exceed INT_DIGITS, or on a second sign or other character.
  - Leading zeros count as digits.
- FRAC:
  - digit: frac_acc = frac_acc*10 + d; nfrac++.
  - TERM: -> PAD.
  - Error on a digit beyond FRAC_DIGITS, a second '.', a sign, or any other character.
- No-digit rule: TERM with nint+nfrac==0 (empty string, "+", "-", ".") is an error.
- PAD: each cycle frac_acc *= 10 and nfrac++; when nfrac==FRAC_DIGITS -> OUT. Zero PAD cycles if the fraction was already full.
- OUT: mag = int_acc*SCALE + frac_acc; float <= negative ? -mag : mag; validout pulses for 1 cycle; clear accumulators, counters and negative; -> SIGN.
- Latency: validout is asserted (FRAC_DIGITS - nfrac) + 1 cycles after the clock edge that accepts TERM.
- Error path:
  - An offending non-TERM character -> FLUSH. FLUSH discards characters until TERM, then error pulses on the cycle after TERM is accepted -> SIGN.
  - An offending TERM (no-digit rule) pulses error on the next cycle -> SIGN.
  - float is unchanged on error; validout and error are never asserted together.
- "-0", "-0.000" produce float=0 with no sign artefact.
- Range: max magnitude 999999.999999 -> 999999999999, which fits in 64 bits; no overflow path beyond the digit-count checks.
- Reset mid-parse: the next cycle is in SIGN with everything cleared; no validout or error pulse for the aborted string.
- Accumulator widths: int_acc 20 bits, frac_acc 20 bits, mag 64 bits; all arithmetic unsigned until the final negate.

Test Plan:
- "+123.45\r" back-to-back -> float=123450000 (0x00000000075BB290); validout 5 cycles after CR accepted; error stays 0.
- "-7\r" -> float=0xFFFFFFFFFF953040 (-7000000); validout 7 cycles after CR; char_ready=0 during PAD/OUT.
- "999999.999999\r" -> float=999999999999; validout 1 cycle after CR; "-0.0\r" next -> float=0.
- "1234567\r" -> 7th digit triggers FLUSH; error pulse the cycle after CR; float keeps its previous value. "12.3.4\r" and "\r" -> error pulse each.
- Random char_valid gaps with "-.5\r" -> float=-500000; characters held while char_ready=0 are not double-counted.
- Assert reset after "45." -> next "8\r" yields float=8000000 with no pulse for the aborted string.

Source files
------------

// File: rtl/str_to_float.sv
// Serial ASCII decimal parser: [sign] digits ['.' digits] TERM -> signed 64-bit value scaled by SCALE.
// One character per valid/ready handshake; result or error reported as single-cycle pulses.
module str_to_float #(
    parameter int unsigned INT_DIGITS  = 6,
    parameter int unsigned FRAC_DIGITS = 6,
    parameter int unsigned SCALE       = 1000000,
    parameter logic [7:0]  TERM        = 8'h0D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [63:0] float,
    output logic        validout,
    output logic        error
);

    localparam int unsigned ACC_W   = 20;
    localparam int unsigned OUT_W   = 64;
    localparam int unsigned MAX_DIG = (INT_DIGITS > FRAC_DIGITS) ? INT_DIGITS : FRAC_DIGITS;
    localparam int unsigned CNT_W   = $clog2(MAX_DIG + 1);

    typedef enum logic [2:0] {
        S_SIGN  = 3'd0,
        S_INT   = 3'd1,
        S_FRAC  = 3'd2,
        S_PAD   = 3'd3,
        S_OUT   = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [ACC_W-1:0]   int_acc;
    logic [ACC_W-1:0]   frac_acc;
    logic [CNT_W-1:0]   nint;
    logic [CNT_W-1:0]   nfrac;
    logic               negative;
    logic [OUT_W-1:0]   mag;

    logic               accept;
    logic               is_digit;
    logic               is_sign;
    logic               is_dot;
    logic               is_term;
    logic               int_full;
    logic               frac_full;
    logic               no_digits;
    logic [ACC_W-1:0]   digit;

    logic               int_push;
    logic               frac_push;
    logic               neg_set;
    logic               pad_step;
    logic               out_load;
    logic               err_set;
    logic               clear;
    logic               ready_nx;

    function automatic logic [ACC_W-1:0] times10(input logic [ACC_W-1:0] a);
        return (a << 3) + (a << 1);
    endfunction

    // Character classification and counter status
    always_comb begin
        accept    = char_valid && char_ready;
        is_digit  = (char_in >= 8'h30) && (char_in <= 8'h39);
        is_sign   = (char_in == 8'h2B) || (char_in == 8'h2D);
        is_dot    = (char_in == 8'h2E);
        is_term   = (char_in == TERM);
        digit     = ACC_W'(char_in[3:0]);
        int_full  = (nint == CNT_W'(INT_DIGITS));
        frac_full = (nfrac == CNT_W'(FRAC_DIGITS));
        no_digits = (nint == '0) && (nfrac == '0);
        mag       = OUT_W'(int_acc) * OUT_W'(SCALE) + OUT_W'(frac_acc);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SIGN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_SIGN: begin
                if (accept) begin
                    if (is_sign || is_digit) begin
                        state_nx = S_INT;
                    end else if (is_dot) begin
                        state_nx = S_FRAC;
                    end else if (!is_term) begin
                        state_nx = S_FLUSH;
                    end
                end
            end
            S_INT: begin
                if (accept) begin
                    if (is_digit) begin
                        if (int_full) state_nx = S_FLUSH;
                    end else if (is_dot) begin
                        state_nx = S_FRAC;
                    end else if (is_term) begin
                        state_nx = no_digits ? S_SIGN : (frac_full ? S_OUT : S_PAD);
                    end else begin
                        state_nx = S_FLUSH;
                    end
                end
            end
            S_FRAC: begin
                if (accept) begin
                    if (is_digit) begin
                        if (frac_full) state_nx = S_FLUSH;
                    end else if (is_term) begin
                        state_nx = no_digits ? S_SIGN : (frac_full ? S_OUT : S_PAD);
                    end else begin
                        state_nx = S_FLUSH;
                    end
                end
            end
            S_PAD: begin
                if (nfrac == CNT_W'(FRAC_DIGITS - 1)) state_nx = S_OUT;
            end
            S_OUT: begin
                state_nx = S_SIGN;
            end
            S_FLUSH: begin
                if (accept && is_term) state_nx = S_SIGN;
            end
            default: begin
                state_nx = S_SIGN;
            end
        endcase
    end

    // Datapath strobes; a TERM with no digits anywhere in the string is rejected
    always_comb begin
        int_push  = 1'b0;
        frac_push = 1'b0;
        neg_set   = 1'b0;
        pad_step  = 1'b0;
        out_load  = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_SIGN: begin
                int_push = accept && is_digit;
                neg_set  = accept && (char_in == 8'h2D);
                err_set  = accept && is_term;
            end
            S_INT: begin
                int_push = accept && is_digit && !int_full;
                err_set  = accept && is_term && no_digits;
            end
            S_FRAC: begin
                frac_push = accept && is_digit && !frac_full;
                err_set   = accept && is_term && no_digits;
            end
            S_PAD:   pad_step = 1'b1;
            S_OUT:   out_load = 1'b1;
            S_FLUSH: err_set  = accept && is_term;
            default: ;
        endcase
        clear    = out_load || err_set;
        ready_nx = (state_nx == S_SIGN) || (state_nx == S_INT) ||
                   (state_nx == S_FRAC) || (state_nx == S_FLUSH);
    end

    // Accumulators and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            float      <= '0;
            validout   <= 1'b0;
            error      <= 1'b0;
            char_ready <= 1'b1;
            int_acc    <= '0;
            frac_acc   <= '0;
            nint       <= '0;
            nfrac      <= '0;
            negative   <= 1'b0;
        end else begin
            validout   <= out_load;
            error      <= err_set;
            char_ready <= ready_nx;
            if (out_load) begin
                float <= negative ? (OUT_W'(0) - mag) : mag;
            end
            if (clear) begin
                int_acc  <= '0;
                frac_acc <= '0;
                nint     <= '0;
                nfrac    <= '0;
                negative <= 1'b0;
            end else begin
                if (int_push) begin
                    int_acc <= times10(int_acc) + digit;
                    nint    <= nint + CNT_W'(1);
                end
                if (frac_push) begin
                    frac_acc <= times10(frac_acc) + digit;
                    nfrac    <= nfrac + CNT_W'(1);
                end
                if (pad_step) begin
                    frac_acc <= times10(frac_acc);
                    nfrac    <= nfrac + CNT_W'(1);
                end
                if (neg_set) begin
                    negative <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_str_to_float.sv
// Bench for str_to_float: directed and random strings scored against a string-level decimal model.
module tb_str_to_float;

    localparam logic [7:0] CR = 8'h0D;

    typedef byte bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [63:0] flt;
    logic        validout;
    logic        error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_float = '0;

    str_to_float dut (
        .clk       (clk),
        .reset     (reset),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .float     (flt),
        .validout  (validout),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t sq(input string s);
        bq_t q;
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(byte'(s[i]));
        return q;
    endfunction

    // Decimal-string reference: value = sign * (intpart * 10^6 + fraction scaled to 6 places)
    function automatic void model(input bq_t body, output bit ok, output logic [63:0] val,
                                  output int nf);
        longint ip, fp;
        int     ni;
        bit     neg, bad, in_frac, started;
        ip = 0; fp = 0; ni = 0; nf = 0;
        neg = 0; bad = 0; in_frac = 0; started = 0;
        foreach (body[i]) begin
            byte c;
            c = body[i];
            if (!bad) begin
                if (c >= 8'h30 && c <= 8'h39) begin
                    if (in_frac) begin
                        if (nf == 6) bad = 1;
                        else begin fp = fp * 10 + longint'(c - 8'h30); nf++; end
                    end else begin
                        if (ni == 6) bad = 1;
                        else begin ip = ip * 10 + longint'(c - 8'h30); ni++; end
                    end
                end else if (c == 8'h2E) begin
                    if (in_frac) bad = 1;
                    else in_frac = 1;
                end else if (c == 8'h2B || c == 8'h2D) begin
                    if (started) bad = 1;
                    else neg = (c == 8'h2D);
                end else begin
                    bad = 1;
                end
                started = 1;
            end
        end
        ok = !bad && (ni + nf > 0);
        for (int k = nf; k < 6; k++) fp = fp * 10;
        val = 64'(ip * 1000000 + fp);
        if (neg) val = 64'(0) - val;
    endfunction

    // Offer one character, wait for it to be accepted, then drop valid just after that edge
    task automatic put(input byte c, input int gap_max);
        int budget;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        budget     = 0;
        while (!char_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) chk("put_ready_timeout", 64'(char_ready), 64'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic run(input string tag, input bq_t body, input int gap_max);
        bit          ok;
        logic [63:0] val;
        int          nf;
        int          k;
        bit          ready_leak;
        model(body, ok, val, nf);
        foreach (body[i]) put(body[i], gap_max);
        put(CR, gap_max);
        k = 0;
        ready_leak = 0;
        // Hold a junk character while the parser is busy; it must not be taken
        while (!validout && !error && k < 40) begin
            if (char_ready) ready_leak = 1;
            char_in    = 8'h37;
            char_valid = !char_ready;
            @(posedge clk);
            #1;
            k++;
        end
        char_valid = 1'b0;
        if (ok) exp_float = val;
        chk({tag, ":validout"}, 64'(validout), 64'(ok));
        chk({tag, ":error"}, 64'(error), 64'(!ok));
        chk({tag, ":latency"}, 64'(k), ok ? 64'(7 - nf) : 64'd0);
        chk({tag, ":float"}, flt, exp_float);
        if (ok) chk({tag, ":ready_busy"}, 64'(ready_leak), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, ":pulse_end"}, 64'({validout, error}), 64'd0);
    endtask

    initial begin
        bq_t q;
        int  ni, nf, r;
        bit  spur;

        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset:float", flt, 64'd0);
        chk("reset:validout", 64'(validout), 64'd0);
        chk("reset:error", 64'(error), 64'd0);
        chk("reset:char_ready", 64'(char_ready), 64'd1);

        run("plus123_45", sq("+123.45"), 0);
        chk("plus123_45:const", flt, 64'h00000000075BB290);
        run("minus7", sq("-7"), 0);
        chk("minus7:const", flt, 64'hFFFFFFFFFF953040);
        run("max", sq("999999.999999"), 0);
        chk("max:const", flt, 64'd999999999999);
        run("neg_zero_frac", sq("-0.0"), 0);
        chk("neg_zero_frac:const", flt, 64'd0);
        run("prev_42", sq("42"), 1);
        run("seven_int", sq("1234567"), 0);
        chk("seven_int:kept", flt, 64'd42000000);
        run("two_dots", sq("12.3.4"), 0);
        run("empty", sq(""), 0);
        run("only_plus", sq("+"), 0);
        run("only_dot", sq("."), 0);
        run("seven_frac", sq("1.1234567"), 0);
        run("inner_sign", sq("12-3"), 0);
        run("neg_zero", sq("-0"), 0);
        run("neg_half_gaps", sq("-.5"), 3);
        chk("neg_half_gaps:const", flt, 64'hFFFFFFFFFFF85EE0);
        run("lead_zeros", sq("000001.000001"), 2);

        // Abort a string with reset, then parse a fresh one
        put(8'h34, 0);
        put(8'h35, 0);
        put(8'h2E, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_float = '0;
        chk("abort:char_ready", 64'(char_ready), 64'd1);
        chk("abort:float", flt, 64'd0);
        spur = 0;
        repeat (4) begin
            if (validout || error) spur = 1;
            @(posedge clk);
            #1;
        end
        chk("abort:no_pulse", 64'(spur), 64'd0);
        run("after_reset", sq("8"), 0);
        chk("after_reset:const", flt, 64'd8000000);

        for (int t = 0; t < 40; t++) begin
            q = {};
            r = int'($urandom_range(2, 0));
            if (r == 1) q.push_back(8'h2B);
            if (r == 2) q.push_back(8'h2D);
            ni = int'($urandom_range(7, 0));
            repeat (ni) q.push_back(byte'(8'h30 + $urandom_range(9, 0)));
            if ($urandom_range(1, 0) == 1) begin
                q.push_back(8'h2E);
                nf = int'($urandom_range(7, 0));
                repeat (nf) q.push_back(byte'(8'h30 + $urandom_range(9, 0)));
            end
            if ($urandom_range(5, 0) == 0) begin
                r = int'($urandom_range(2, 0));
                q.insert(int'($urandom_range(q.size(), 0)),
                         (r == 0) ? byte'(8'h78) : (r == 1) ? byte'(8'h2E) : byte'(8'h2D));
            end
            run($sformatf("rnd%0d", t), q, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
